// File: rtl/rcv_controller.sv
// UART receive sequencer: line synchroniser, start-bit qualification, mid-bit
// shift strobes, stop-bit check and a one-deep receive buffer with status flags.
module rcv_controller #(
    parameter int CLKS_PER_BIT = 10,
    parameter int NUM_BITS     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic [NUM_BITS-1:0] sr_data,
    input  logic                data_read,
    output logic                sync_out,
    output logic                shift_enable,
    output logic [NUM_BITS-1:0] rx_data,
    output logic                data_ready,
    output logic                framing_error,
    output logic                overrun_error,
    output logic                busy
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(NUM_BITS + 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        LOAD  = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            sync_1;
    logic            sync_2;
    logic            prev;
    logic [TW-1:0]   timer_q;
    logic [BW-1:0]   bit_cnt_q;
    logic            fall;
    logic            sample_tick;
    logic            start_ok;
    logic            stop_bad;
    logic            load_byte;

    assign sync_out    = sync_2;
    assign fall        = prev & ~sync_2;
    assign sample_tick = (timer_q == '0);

    // Synchroniser resets to idle-high so leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            prev   <= 1'b1;
        end else begin
            sync_1 <= serial_in;
            sync_2 <= sync_1;
            prev   <= sync_2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fall) state_d = START;
            START:   if (sample_tick) state_d = sync_2 ? IDLE : DATA;
            DATA:    if (sample_tick && (bit_cnt_q == LAST_BIT)) state_d = STOP;
            STOP:    if (sample_tick) state_d = sync_2 ? LOAD : IDLE;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_enable = 1'b0;
        busy         = 1'b1;
        start_ok     = 1'b0;
        stop_bad     = 1'b0;
        load_byte    = 1'b0;
        case (state_q)
            IDLE:    busy = 1'b0;
            START:   start_ok = sample_tick & ~sync_2;
            DATA:    shift_enable = sample_tick;
            STOP:    stop_bad = sample_tick & ~sync_2;
            LOAD:    load_byte = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Timer counts down to the next sample point; the first load lands on mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q   <= '0;
            bit_cnt_q <= '0;
        end else if (state_d != state_q) begin
            bit_cnt_q <= '0;
            case (state_d)
                START:   timer_q <= HALF_LOAD;
                DATA:    timer_q <= BIT_LOAD;
                STOP:    timer_q <= BIT_LOAD;
                default: timer_q <= '0;
            endcase
        end else if (state_q == DATA && sample_tick) begin
            timer_q   <= BIT_LOAD;
            bit_cnt_q <= bit_cnt_q + 1'b1;
        end else if (!sample_tick) begin
            timer_q <= timer_q - 1'b1;
        end
    end

    // Host handshake: data_ready high means rx_data holds an unread byte; a data_read
    // pulse while data_ready is high consumes it. A load in the same cycle takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data       <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if (start_ok) framing_error <= 1'b0;
            if (stop_bad) framing_error <= 1'b1;
            if (load_byte) begin
                rx_data    <= sr_data;
                data_ready <= 1'b1;
                if (data_ready && !data_read) begin
                    overrun_error <= 1'b1;
                end else if (data_ready && data_read) begin
                    overrun_error <= 1'b0;
                end
            end else if (data_read && data_ready) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rcv_controller.sv
// Directed bench for rcv_controller: frames are driven bit by bit and a small
// shift-register model feeds sr_data, so received bytes depend on strobe timing.
module tb_rcv_controller;

    logic       clk;
    logic       rst;
    logic       serial_in;
    logic [7:0] sr_data;
    logic       data_read;
    logic       sync_out;
    logic       shift_enable;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulse_q[$];
    logic [7:0] sr_model = 8'h00;

    rcv_controller #(.CLKS_PER_BIT(10), .NUM_BITS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .sr_data       (sr_data),
        .data_read     (data_read),
        .sync_out      (sync_out),
        .shift_enable  (shift_enable),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // external shift register, LSB first; also logs the cycle of every strobe
    assign sr_data = sr_model;
    always @(negedge clk) begin
        if (shift_enable === 1'b1) begin
            sr_model <= {sync_out, sr_model[7:1]};
            pulse_q.push_back(cyc);
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read_pulse();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
    endtask

    // offsets: start 0..9, data bit k at 10+10k.., stop 90..99; LOAD falls at offset 98
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int rst_at,
                              input int read_at, output int start_cyc);
        start_cyc = cyc;
        for (int i = 0; i < 100; i++) begin
            if (i < 10) serial_in = 1'b0;
            else if (i < 90) serial_in = b[(i - 10) / 10];
            else serial_in = stop_bit;
            data_read = (i == read_at);
            rst = (i == rst_at);
            if (i == rst_at) serial_in = 1'b1;
            tick();
            if (i == rst_at) break;
        end
        serial_in = 1'b1;
        data_read = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        serial_in = 1'b1;
        data_read = 1'b0;
        repeat (3) tick();
        total++; if (rx_data !== 8'h00) begin $display("FAIL reset_rx_data got=%h exp=00", rx_data); bad++; end
        total++; if ({data_ready, framing_error, overrun_error} !== 3'b000) begin
            $display("FAIL reset_flags got=%b exp=000", {data_ready, framing_error, overrun_error}); bad++; end
        total++; if ({busy, shift_enable} !== 2'b00) begin
            $display("FAIL reset_busy_shift got=%b exp=00", {busy, shift_enable}); bad++; end
        total++; if (sync_out !== 1'b1) begin $display("FAIL reset_sync_out got=%b exp=1", sync_out); bad++; end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_good_frame();
        int n;
        int base;
        logic [31:0] exp_q[$];
        base = pulse_q.size();
        send_frame(8'hA5, 1'b1, -1, -1, n);
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(n + 17 + 10 * k));
        total++; if (pulse_q.size() - base !== 8) begin
            $display("FAIL a5_pulse_count got=%0d exp=8", pulse_q.size() - base); bad++; end
        for (int k = 0; k < 8 && base + k < pulse_q.size(); k++) begin
            total++; if (32'(pulse_q[base + k]) !== exp_q[k]) begin
                $display("FAIL a5_pulse_time k=%0d got=%0d exp=%0d", k, pulse_q[base + k], exp_q[k]); bad++; end
        end
        total++; if (rx_data !== 8'hA5) begin $display("FAIL a5_rx_data got=%h exp=a5", rx_data); bad++; end
        total++; if ({data_ready, framing_error, overrun_error} !== 3'b100) begin
            $display("FAIL a5_flags got=%b exp=100", {data_ready, framing_error, overrun_error}); bad++; end
        total++; if (busy !== 1'b0) begin $display("FAIL a5_busy_after got=%b exp=0", busy); bad++; end
        idle(4);
    endtask

    task automatic test_glitch();
        int base;
        base = pulse_q.size();
        serial_in = 1'b0;
        repeat (3) tick();
        serial_in = 1'b1;
        repeat (4) tick();
        total++; if (busy !== 1'b1) begin $display("FAIL glitch_busy_t0p5 got=%b exp=1", busy); bad++; end
        tick();
        total++; if (busy !== 1'b0) begin $display("FAIL glitch_busy_t0p6 got=%b exp=0", busy); bad++; end
        idle(30);
        total++; if (pulse_q.size() - base !== 0) begin
            $display("FAIL glitch_pulses got=%0d exp=0", pulse_q.size() - base); bad++; end
        total++; if ({rx_data, data_ready, framing_error, overrun_error} !== {8'hA5, 3'b100}) begin
            $display("FAIL glitch_state got=%h/%b exp=a5/100", rx_data, {data_ready, framing_error, overrun_error}); bad++; end
    endtask

    task automatic test_framing();
        int n;
        int base;
        read_pulse();
        total++; if (data_ready !== 1'b0) begin $display("FAIL fe_pre_read got=%b exp=0", data_ready); bad++; end
        idle(3);
        base = pulse_q.size();
        send_frame(8'h3C, 1'b0, -1, -1, n);
        total++; if (pulse_q.size() - base !== 8) begin
            $display("FAIL fe_pulse_count got=%0d exp=8", pulse_q.size() - base); bad++; end
        total++; if ({rx_data, data_ready, framing_error} !== {8'hA5, 2'b01}) begin
            $display("FAIL fe_bad_stop got=%h/%b exp=a5/01", rx_data, {data_ready, framing_error}); bad++; end
        idle(5);
        send_frame(8'h11, 1'b1, -1, -1, n);
        total++; if ({rx_data, data_ready, framing_error} !== {8'h11, 2'b10}) begin
            $display("FAIL fe_recover got=%h/%b exp=11/10", rx_data, {data_ready, framing_error}); bad++; end
        idle(4);
    endtask

    task automatic test_overrun();
        int n;
        read_pulse();
        idle(3);
        send_frame(8'h12, 1'b1, -1, -1, n);
        idle(4);
        total++; if ({rx_data, data_ready, overrun_error} !== {8'h12, 2'b10}) begin
            $display("FAIL ov_first got=%h/%b exp=12/10", rx_data, {data_ready, overrun_error}); bad++; end
        send_frame(8'h34, 1'b1, -1, -1, n);
        total++; if ({rx_data, data_ready, overrun_error} !== {8'h34, 2'b11}) begin
            $display("FAIL ov_second got=%h/%b exp=34/11", rx_data, {data_ready, overrun_error}); bad++; end
        idle(2);
        read_pulse();
        total++; if ({data_ready, overrun_error} !== 2'b00) begin
            $display("FAIL ov_read_clear got=%b exp=00", {data_ready, overrun_error}); bad++; end
        idle(4);
    endtask

    task automatic test_mid_reset();
        int n;
        int base;
        send_frame(8'h5A, 1'b1, 55, -1, n);
        total++; if ({rx_data, data_ready, framing_error, overrun_error, busy, shift_enable} !== 13'h0) begin
            $display("FAIL mr_outputs got=%h/%b exp=00/00000", rx_data,
                     {data_ready, framing_error, overrun_error, busy, shift_enable}); bad++; end
        base = pulse_q.size();
        idle(50);
        total++; if ((pulse_q.size() - base !== 0) || busy !== 1'b0) begin
            $display("FAIL mr_quiet pulses=%0d busy=%b exp=0/0", pulse_q.size() - base, busy); bad++; end
        send_frame(8'hC3, 1'b1, -1, -1, n);
        total++; if ({rx_data, data_ready, framing_error, overrun_error} !== {8'hC3, 3'b100}) begin
            $display("FAIL mr_next_frame got=%h/%b exp=c3/100", rx_data, {data_ready, framing_error, overrun_error}); bad++; end
        idle(4);
    endtask

    task automatic test_read_at_load();
        int n;
        total++; if (data_ready !== 1'b1) begin $display("FAIL rl_pre_ready got=%b exp=1", data_ready); bad++; end
        send_frame(8'h7E, 1'b1, -1, 98, n);
        total++; if ({rx_data, data_ready, overrun_error} !== {8'h7E, 2'b10}) begin
            $display("FAIL rl_load_wins got=%h/%b exp=7e/10", rx_data, {data_ready, overrun_error}); bad++; end
        idle(2);
        read_pulse();
        total++; if (data_ready !== 1'b0) begin $display("FAIL rl_final_read got=%b exp=0", data_ready); bad++; end
    endtask

    initial begin
        rst       = 1'b1;
        serial_in = 1'b1;
        data_read = 1'b0;
        tick();
        test_reset();
        test_good_frame();
        test_glitch();
        test_framing();
        test_overrun();
        test_mid_reset();
        test_read_at_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
